// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared defaults and occupancy-width helper for the d_ff_pipe register chain
package d_ff_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/d_ff_pipe_if.sv
// d_ff_pipe_if: valid/ready bus around d_ff_pipe; master = upstream/downstream driver side, slave = pipeline
//   flush, in_valid, in_data, out_ready : driven by master
//   in_ready, out_valid, out_data, occupancy : driven by slave
interface d_ff_pipe_if
  import d_ff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [occ_w(DEPTH)-1:0] occupancy;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/d_ff_pipe_stage.sv
// d_ff_pipe_stage: one pipeline stage, a valid bit plus WIDTH data bits
//   clk, rst       : clock, async active-high reset (valid=0, data=RST_VAL)
//   load           : stage may take the upstream beat this edge
//   clr            : sync clear of valid, wins over load, data untouched
//   in_valid/data  : upstream stage contents
//   valid/data     : this stage's contents
module d_ff_pipe_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= 1'b0;
    else if (clr) valid <= 1'b0;
    else if (load) valid <= in_valid;
  // Bubbles pass through without disturbing the data register.
  always_ff @(posedge clk or posedge rst)
    if (rst) data <= RST_VAL;
    else if (!clr && load && in_valid) data <= in_data;
endmodule

// File: rtl/d_ff_pipe.sv
// d_ff_pipe: WIDTH x DEPTH elastic register pipeline with flush and registered occupancy
//   clk, rst : clock, async active-high reset
//   bus      : d_ff_pipe_if.slave (flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupancy)
module d_ff_pipe
  import d_ff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic        clk,
  input logic        rst,
  d_ff_pipe_if.slave bus
);
  localparam int OW = occ_w(DEPTH);
  if (DEPTH < 1) begin : g_depth_check
    $error("d_ff_pipe: DEPTH must be >= 1");
  end
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   ready;
  logic             push;
  logic             pop;
  logic [OW-1:0]    occ;
  // Combinational ready chain from out_ready back to stage 0; no skid buffer.
  always_comb begin
    ready[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) ready[i] = !valid[i] | ready[i+1];
  end
  assign bus.in_ready  = ready[0] & !bus.flush & !rst;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = valid[DEPTH-1] & bus.out_ready;
  assign bus.out_valid = valid[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];
  assign bus.occupancy = occ;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    if (g == 0) begin : g_head
      assign up_valid = push;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = valid[g-1];
      assign up_data  = data[g-1];
    end
    d_ff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (ready[g]),
      .clr      (bus.flush),
      .in_valid (up_valid),
      .in_data  (up_data),
      .valid    (valid[g]),
      .data     (data[g])
    );
  end
  // Tracks popcount of valid bits incrementally; push is impossible during flush.
  always_ff @(posedge clk or posedge rst)
    if (rst) occ <= '0;
    else occ <= bus.flush ? '0 : occ + OW'(push) - OW'(pop);
endmodule
